clm_inverter: RTL and testbench

- Sequential controller that computes the GF(2^8) multiplicative inverse, x^254, of one CLM-encoded state_t codeword.
- It is the stage directly upstream and downstream of the combinational CLM multiplier: it drives the multiplier's p1, p2 and r inputs and registers its out.
- It sits in the S-box datapath ahead of the affine stage.
- Each multiplication takes one cycle. Every product gets a fresh redundancy term r from the randomness source.

---
 rtl/clm_inverter_pkg.sv | 26 ++
 rtl/clm_inverter.sv | 111 +++++++++++
 tb/tb_clm_inverter.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clm_inverter_pkg.sv
// -----------------------------------------------------------------------------
// clm_inverter_pkg
// Shared types for the CLM-encoded S-box datapath.
//   d          : redundancy width of a CLM codeword
//   state_t    : CLM codeword (8 information bits + d redundancy bits)
//   red_poly_t : fresh redundancy / refresh term fed to the multiplier
//   inv_state_t: controller states of the x^254 inverter
// -----------------------------------------------------------------------------
package clm_inverter_pkg;

    localparam int d = 4;

    typedef logic [8+d-1:0] state_t;
    typedef logic [d-1:0]   red_poly_t;

    // Number of square+multiply rounds before the closing square of x^254.
    localparam int INV_NUM_ROUNDS = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL_SQ = 2'd1,
        MUL_X  = 2'd2,
        DONE   = 2'd3
    } inv_state_t;

endpackage

// File: rtl/clm_inverter.sv
// -----------------------------------------------------------------------------
// clm_inverter
// Computes the GF(2^8) inverse x^254 of one CLM codeword by driving an
// external combinational CLM multiplier, one product per cycle.
// Addition chain: 1 -> 2 -> 3 -> 6 -> 7 -> ... -> 126 -> 127 -> 254
// (7 squares, 6 multiplies by x). Every product consumes one fresh rnd_data.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready/in_data      codeword input handshake
//   rnd_valid/rnd_ready/rnd_data   randomness source handshake
//   mul_p1, mul_p2, mul_r          operands to the external multiplier
//   mul_out                        product returned by the multiplier
//   out_valid/out_ready/out_data   result handshake (x^254 codeword)
// -----------------------------------------------------------------------------
module clm_inverter
    import clm_inverter_pkg::*;
#(
    parameter int NUM_ROUNDS = INV_NUM_ROUNDS
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      in_valid,
    output logic      in_ready,
    input  state_t    in_data,
    input  logic      rnd_valid,
    output logic      rnd_ready,
    input  red_poly_t rnd_data,
    output state_t    mul_p1,
    output state_t    mul_p2,
    output red_poly_t mul_r,
    input  state_t    mul_out,
    output logic      out_valid,
    input  logic      out_ready,
    output state_t    out_data
);

    localparam logic [2:0] LAST_CNT = 3'(NUM_ROUNDS);

    inv_state_t r_state;
    state_t     r_x;
    state_t     r_acc;
    logic [2:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x     <= in_data;
                        r_acc   <= in_data;
                        r_cnt   <= '0;
                        r_state <= MUL_SQ;
                    end
                end
                MUL_SQ: begin
                    // A missing refresh term stalls the chain: acc holds.
                    if (rnd_valid) begin
                        r_acc   <= mul_out;
                        r_state <= (r_cnt == LAST_CNT) ? DONE : MUL_X;
                    end
                end
                MUL_X: begin
                    if (rnd_valid) begin
                        r_acc   <= mul_out;
                        r_cnt   <= r_cnt + 3'd1;
                        r_state <= MUL_SQ;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        out_data  = r_acc;
        mul_p1    = '0;
        mul_p2    = '0;
        mul_r     = '0;
        rnd_ready = 1'b0;
        case (r_state)
            MUL_SQ: begin
                mul_p1    = r_acc;
                mul_p2    = r_acc;
                mul_r     = rnd_data;
                rnd_ready = rnd_valid;
            end
            MUL_X: begin
                mul_p1    = r_acc;
                mul_p2    = r_x;
                mul_r     = rnd_data;
                rnd_ready = rnd_valid;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_clm_inverter.sv
// -----------------------------------------------------------------------------
// tb_clm_inverter
// Drives random codewords and randomness into clm_inverter, supplies a
// behavioural CLM multiplier (polynomial ring mod P*Q, decode = mod P with
// P = AES polynomial), and checks results against a brute-force GF(2^8)
// inverse through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_clm_inverter;
    import clm_inverter_pkg::*;

    localparam logic [11:0] P_POLY = 12'h11B;
    localparam logic [11:0] Q_POLY = 12'h013;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      in_valid;
    logic      in_ready;
    state_t    in_data;
    logic      rnd_valid;
    logic      rnd_ready;
    red_poly_t rnd_data;
    state_t    mul_p1;
    state_t    mul_p2;
    red_poly_t mul_r;
    state_t    mul_out;
    logic      out_valid;
    logic      out_ready;
    state_t    out_data;

    always #5 clk = ~clk;

    clm_inverter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .rnd_data  (rnd_data),
        .mul_p1    (mul_p1),
        .mul_p2    (mul_p2),
        .mul_r     (mul_r),
        .mul_out   (mul_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [23:0] pmul(input logic [11:0] a, input logic [11:0] b);
        logic [23:0] t;
        t = '0;
        for (int i = 0; i < 12; i++) if (b[i]) t = t ^ ({12'b0, a} << i);
        return t;
    endfunction

    function automatic logic [11:0] clm_mul(input logic [11:0] a, input logic [11:0] b,
                                            input logic [3:0] r);
        logic [23:0] t;
        logic [23:0] m;
        m = pmul(P_POLY, Q_POLY);
        t = pmul(a, b) ^ pmul({8'b0, r}, P_POLY);
        for (int i = 23; i >= 12; i--) if (t[i]) t = t ^ (m << (i - 12));
        return t[11:0];
    endfunction

    function automatic logic [7:0] decode(input logic [11:0] c);
        logic [11:0] t;
        t = c;
        for (int i = 11; i >= 8; i--) if (t[i]) t = t ^ (P_POLY << (i - 8));
        return t[7:0];
    endfunction

    function automatic logic [11:0] encode(input logic [7:0] v, input logic [3:0] k);
        logic [23:0] t;
        t = pmul({8'b0, k}, P_POLY);
        return {4'b0, v} ^ t[11:0];
    endfunction

    function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] p;
        x = a;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] inv8(input logic [7:0] v);
        for (int b = 1; b < 256; b++) if (gf_mul8(v, 8'(b)) == 8'h01) return 8'(b);
        return 8'h00;
    endfunction

    always_comb mul_out = clm_mul(mul_p1, mul_p2, mul_r);

    // ---------------- scoreboard bookkeeping ----------------
    typedef struct {
        logic [11:0] x;
        logic [7:0]  exp_info;
        bit          exact;
        logic [11:0] exact_val;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- randomness / downstream driver ----------------
    int cyc = 0;
    int acc_cyc = 0;
    int rnd_mode = 0;  // 0: valid, data 0; 1: valid, random; 2: 75% valid; 3: stalls at 3,4,9
    int or_mode = 0;   // 0: ready; 1: random; 2: not ready

    initial begin
        rnd_valid = 1'b1;
        rnd_data  = '0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            case (rnd_mode)
                0: begin rnd_valid = 1'b1; rnd_data = '0; end
                1: begin rnd_valid = 1'b1; rnd_data = 4'($urandom); end
                2: begin rnd_valid = ($urandom_range(0, 3) != 0); rnd_data = 4'($urandom); end
                default: begin
                    rnd_valid = !((cyc - acc_cyc) inside {3, 4, 9});
                    rnd_data  = 4'($urandom);
                end
            endcase
            case (or_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    bit          busy = 0;
    bit          holding = 0;
    int          nprod = 0;
    int          nrdy = 0;
    logic [11:0] last_prod = '0;
    logic [11:0] hold_data = '0;

    initial begin
        logic [11:0] e_p1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_in_ready", in_ready, 1);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_rnd_ready", rnd_ready, 0);
                chk("rst_out_data", out_data, 0);
                q.delete();
                busy = 0;
                holding = 0;
            end else if (out_valid) begin
                chk("done_nprod", nprod, 13);
                chk("done_in_ready", in_ready, 0);
                chk("done_rnd_ready", rnd_ready, 0);
                chk("done_mul_zero", {mul_p1, mul_p2, mul_r}, 0);
                if (holding) chk("out_hold", out_data, hold_data);
                if (q.size() == 0) begin
                    flag("out_unexpected");
                end else begin
                    if (!holding) begin
                        chk("out_decode", decode(out_data), q[0].exp_info);
                        if (q[0].exact) chk("out_exact", out_data, q[0].exact_val);
                        chk("rnd_ready_count", nrdy, 13);
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        busy = 0;
                        holding = 0;
                        done_cnt++;
                    end else begin
                        holding = 1;
                        hold_data = out_data;
                    end
                end
            end else if (busy) begin
                chk("busy_in_ready", in_ready, 0);
                chk("busy_rnd_ready", rnd_ready, rnd_valid);
                chk("busy_mul_r", mul_r, rnd_data);
                if (nprod >= 13) begin
                    flag("out_late");
                    busy = 0;
                end else if (q.size() != 0) begin
                    e_p1 = (nprod == 0) ? q[0].x : last_prod;
                    chk("mul_p1", mul_p1, e_p1);
                    chk("mul_p2", mul_p2, (nprod % 2 == 0) ? e_p1 : q[0].x);
                end
                if (rnd_valid) begin
                    last_prod = mul_out;
                    nprod++;
                end
                if (rnd_ready) nrdy++;
            end else begin
                chk("idle_in_ready", in_ready, 1);
                chk("idle_rnd_ready", rnd_ready, 0);
                chk("idle_mul_zero", {mul_p1, mul_p2, mul_r}, 0);
                if (in_valid) begin
                    busy = 1;
                    nprod = 0;
                    nrdy = 0;
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send(input logic [11:0] c, input bit exact, input logic [11:0] ev);
        exp_t e;
        int   k;
        in_data  = c;
        in_valid = 1'b1;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready && rst_n) break;
        end
        if (k == 300) begin
            flag("send_timeout");
            in_valid = 1'b0;
            return;
        end
        acc_cyc     = cyc;
        e.x         = c;
        e.exp_info  = inv8(decode(c));
        e.exact     = exact;
        e.exact_val = ev;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (out_valid) return;
            lat++;
        end
        flag("out_valid_timeout");
    endtask

    task automatic wait_done(input int start);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (done_cnt != start) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        flag("done_timeout");
    endtask

    task automatic run_one(input logic [11:0] c, input bit exact, input logic [11:0] ev,
                           input int exp_lat);
        int start;
        int lat;
        start = done_cnt;
        send(c, exact, ev);
        wait_out(lat);
        if (exp_lat > 0) chk("latency", lat, exp_lat);
        wait_done(start);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int start;
        int lat;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // zero codeword, zero randomness
        rnd_mode = 0;
        run_one(12'h000, 1, 12'h000, 14);
        // systematic 0x01 stays exactly 0x001
        run_one(12'h001, 1, 12'h001, 14);
        // nonzero codeword with zero information part
        rnd_mode = 1;
        run_one(P_POLY, 0, 12'h000, 14);
        // 0x53 -> 0xCA with random refresh
        run_one(encode(8'h53, 4'($urandom)), 0, 12'h000, 14);
        // stalls on cycles 3, 4 and 9
        rnd_mode = 3;
        run_one(encode(8'h53, 4'($urandom)), 0, 12'h000, 17);
        rnd_mode = 1;

        // back-pressure: result held for 5 cycles with a competing input
        or_mode = 2;
        start = done_cnt;
        send(encode(8'hA7, 4'($urandom)), 0, 12'h000);
        wait_out(lat);
        chk("hold_latency", lat, 14);
        repeat (5) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_data  = 12'($urandom);
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        or_mode  = 0;
        wait_done(start);
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // reset in the middle of a computation
        send(encode(8'h3C, 4'($urandom)), 0, 12'h000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_acc", out_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        run_one(encode(8'h3C, 4'($urandom)), 0, 12'h000, 14);

        // full sweep with random refresh, stalls and back-pressure
        rnd_mode = 2;
        or_mode  = 1;
        for (int v = 0; v < 256; v++) begin
            start = done_cnt;
            send(encode(8'(v), 4'($urandom)), 0, 12'h000);
            wait_done(start);
        end
        or_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
